// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the E-stage multiply/divide unit.
// Holds the hilo_op encoding (also used by E_REG users and the main control
// unit), the default busy latencies, the unit's FSM state type and a small
// helper that recognises the multi-cycle opcodes.
package md_pkg;

  localparam int HILO_OP_W       = 4;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Opcodes 9..15 are unused and behave as HILO_NONE.
  typedef enum logic [HILO_OP_W-1:0] {
    HILO_NONE  = 4'd0,
    HILO_MULT  = 4'd1,
    HILO_MULTU = 4'd2,
    HILO_DIV   = 4'd3,
    HILO_DIVU  = 4'd4,
    HILO_MTHI  = 4'd5,
    HILO_MTLO  = 4'd6,
    HILO_MFHI  = 4'd7,
    HILO_MFLO  = 4'd8
  } hilo_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  // True for the opcodes that launch a multi-cycle operation.
  function automatic logic is_md_op(input logic [HILO_OP_W-1:0] op);
    return (op == HILO_MULT) || (op == HILO_MULTU) ||
           (op == HILO_DIV)  || (op == HILO_DIVU);
  endfunction

endpackage

// File: rtl/md_div32.sv
// md_div32: combinational 32-bit divider, signed or unsigned.
// Ports:
//   dividend, divisor  in 32 : operands (rs / rt)
//   is_signed          in 1  : 1 = DIV semantics, 0 = DIVU semantics
//   quotient           out 32: truncated toward zero
//   remainder          out 32: carries the sign of the dividend (signed mode)
//   div_by_zero        out 1 : divisor is zero; quotient/remainder forced to 0
module md_div32 (
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        is_signed,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero
);

  logic        dvd_neg;
  logic        dvs_neg;
  logic [31:0] dvd_mag;
  logic [31:0] dvs_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic        overflow_case;

  assign div_by_zero = (divisor == 32'd0);
  assign dvd_neg     = is_signed & dividend[31];
  assign dvs_neg     = is_signed & divisor[31];

  // Signed division is done on magnitudes. 0x80000000 has no positive
  // counterpart but its two's complement is itself, which is still the
  // correct unsigned magnitude.
  assign dvd_mag = dvd_neg ? (~dividend + 32'd1) : dividend;

  // A zero divisor is replaced by 1 so the divide core never sees zero;
  // its result is discarded below anyway.
  assign dvs_mag = div_by_zero ? 32'd1 :
                   (dvs_neg ? (~divisor + 32'd1) : divisor);

  assign q_mag = dvd_mag / dvs_mag;
  assign r_mag = dvd_mag % dvs_mag;

  // The one signed quotient that overflows 32 bits wraps to 0x80000000.
  assign overflow_case = is_signed && (dividend == 32'h8000_0000) &&
                         (divisor == 32'hFFFF_FFFF);

  always_comb begin
    quotient  = 32'd0;
    remainder = 32'd0;
    if (div_by_zero) begin
      quotient  = 32'd0;
      remainder = 32'd0;
    end else if (overflow_case) begin
      quotient  = 32'h8000_0000;
      remainder = 32'd0;
    end else begin
      quotient  = (dvd_neg ^ dvs_neg) ? (~q_mag + 32'd1) : q_mag;
      remainder = dvd_neg ? (~r_mag + 32'd1) : r_mag;
    end
  end

endmodule

// File: rtl/e_muldiv_unit.sv
// e_muldiv_unit: E-stage multiply/divide unit holding architectural HI/LO.
// A mult/div is accepted from the D->E control pair (start, hilo_op), its
// 64-bit result is captured into temporaries immediately, and HI/LO are
// written when the busy countdown expires. MTHI/MTLO write HI/LO directly.
// Ports:
//   clk, reset      in 1  : clock, synchronous active-high reset
//   req             in 1  : exception/interrupt; E-stage instruction not committed
//   start           in 1  : E-stage instruction is mult/multu/div/divu
//   hilo_op         in 4  : operation code (md_pkg::hilo_op_e)
//   rs_val, rt_val  in 32 : forwarded operands
//   busy            out 1 : operation in progress (registered)
//   hi, lo          out 32: architectural HI/LO
//   hilo_out        out 32: hi for MFHI, lo for MFLO, else 0 (combinational)
module e_muldiv_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req,
  input  logic                 start,
  input  logic [HILO_OP_W-1:0] hilo_op,
  input  logic [31:0]          rs_val,
  input  logic [31:0]          rt_val,
  output logic                 busy,
  output logic [31:0]          hi,
  output logic [31:0]          lo,
  output logic [31:0]          hilo_out
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_e        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [31:0]      t_hi, t_hi_n;
  logic [31:0]      t_lo, t_lo_n;
  logic             nowrite, nowrite_n;
  logic [31:0]      hi_n, lo_n;

  logic [63:0]      mult_s;
  logic [63:0]      mult_u;
  logic [63:0]      result;
  logic             op_is_div;
  logic             div_signed;
  logic [31:0]      div_quo;
  logic [31:0]      div_rem;
  logic             div_zero;
  logic             accept;

  assign op_is_div  = (hilo_op == HILO_DIV) || (hilo_op == HILO_DIVU);
  assign div_signed = (hilo_op == HILO_DIV);

  // Both products are formed at full 64-bit width from extended operands so
  // the upper half is exact.
  assign mult_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
  assign mult_u = {32'd0, rs_val} * {32'd0, rt_val};

  md_div32 u_div (
    .dividend   (rs_val),
    .divisor    (rt_val),
    .is_signed  (div_signed),
    .quotient   (div_quo),
    .remainder  (div_rem),
    .div_by_zero(div_zero)
  );

  always_comb begin
    result = 64'd0;
    case (hilo_op)
      HILO_MULT:  result = mult_s;
      HILO_MULTU: result = mult_u;
      HILO_DIV,
      HILO_DIVU:  result = {div_rem, div_quo};
      default:    result = 64'd0;
    endcase
  end

  // A launch needs an idle unit and a committed instruction; reset is
  // handled by the register process taking priority.
  assign accept = (state == MD_IDLE) && start && is_md_op(hilo_op) && !req;

  // Next-state logic. In IDLE the unit either accepts a launch or services
  // MTHI/MTLO; in RUN it only counts down, ignoring req (the instruction is
  // already committed) and any new command. The 1->0 count edge performs
  // the deferred HI/LO write, suppressed after a divide by zero.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    t_hi_n    = t_hi;
    t_lo_n    = t_lo;
    nowrite_n = nowrite;
    hi_n      = hi;
    lo_n      = lo;
    case (state)
      MD_IDLE: begin
        if (accept) begin
          state_n   = MD_RUN;
          cnt_n     = op_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          t_hi_n    = result[63:32];
          t_lo_n    = result[31:0];
          nowrite_n = op_is_div && div_zero;
        end else if (!req && (hilo_op == HILO_MTHI)) begin
          hi_n = rs_val;
        end else if (!req && (hilo_op == HILO_MTLO)) begin
          lo_n = rs_val;
        end
      end
      MD_RUN: begin
        cnt_n = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_n   = MD_IDLE;
          nowrite_n = 1'b0;
          if (!nowrite) begin
            hi_n = t_hi;
            lo_n = t_lo;
          end
        end
      end
      default: state_n = MD_IDLE;
    endcase
  end

  // State register. Reset aborts any operation in flight and clears HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= MD_IDLE;
      cnt     <= '0;
      t_hi    <= 32'd0;
      t_lo    <= 32'd0;
      nowrite <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      t_hi    <= t_hi_n;
      t_lo    <= t_lo_n;
      nowrite <= nowrite_n;
      hi      <= hi_n;
      lo      <= lo_n;
    end
  end

  assign busy = (state == MD_RUN);

  // Read port for MFHI/MFLO. A same-cycle MT write is not bypassed here.
  always_comb begin
    hilo_out = 32'd0;
    case (hilo_op)
      HILO_MFHI: hilo_out = hi;
      HILO_MFLO: hilo_out = lo;
      default:   hilo_out = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_e_muldiv_unit.sv
// tb_e_muldiv_unit: scoreboard bench for e_muldiv_unit.
// Inputs change on the falling edge and outputs are sampled there, half a
// period away from the rising edge the DUT uses.
module tb_e_muldiv_unit;
  import md_pkg::*;

  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        start;
  logic [3:0]  hilo_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] hilo_out;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model_hi;
  logic [31:0] model_lo;
  int          errors      = 0;
  int          checks      = 0;
  int          illegal_cnt = 0;

  e_muldiv_unit dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .start   (start),
    .hilo_op (hilo_op),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo),
    .hilo_out(hilo_out)
  );

  always #5 clk = ~clk;

  // The hazard unit must never issue start/MTHI/MTLO while busy; record
  // every edge where that happens so the bench can confirm it is seen.
  always @(posedge clk) begin
    if (!reset && busy && (start || hilo_op == HILO_MTHI || hilo_op == HILO_MTLO)) begin
      illegal_cnt++;
      $display("[TB] note: HI/LO command issued while busy at %0t", $time);
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Reference result {hi,lo}; a divide by zero leaves the current value.
  function automatic logic [63:0] modelResult(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    int              ia, ib, q, rm;
    logic [63:0]     r;
    r = {model_hi, model_lo};
    case (op)
      HILO_MULT: begin
        sa = $signed(a);
        sb = $signed(b);
        r  = sa * sb;
      end
      HILO_MULTU: begin
        ua = {32'd0, a};
        ub = {32'd0, b};
        r  = ua * ub;
      end
      HILO_DIV: begin
        if (b != 32'd0) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = {32'd0, 32'h8000_0000};
          end else begin
            ia = $signed(a);
            ib = $signed(b);
            q  = ia / ib;
            rm = ia % ib;
            r  = {rm, q};
          end
        end
      end
      HILO_DIVU: begin
        if (b != 32'd0) r = {a % b, a / b};
      end
      default: ;
    endcase
    return r;
  endfunction

  // Drives one command for one cycle starting at a falling edge and returns
  // on the next falling edge (cycle 1). Assumes the unit is idle.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic rq);
    exp_t e;
    start   = is_md_op(op);
    hilo_op = op;
    rs_val  = a;
    rt_val  = b;
    req     = rq;
    if (is_md_op(op) && !rq) begin
      {e.hi, e.lo} = modelResult(op, a, b);
      e.lat        = (op == HILO_DIV || op == HILO_DIVU) ? DIV_LAT : MUL_LAT;
      sb_q.push_back(e);
    end else if (!rq && op == HILO_MTHI) begin
      model_hi = a;
    end else if (!rq && op == HILO_MTLO) begin
      model_lo = a;
    end
    @(negedge clk);
    start   = 1'b0;
    hilo_op = HILO_NONE;
    req     = 1'b0;
  endtask

  // Counts busy cycles (bounded), optionally pulsing req at busy cycle
  // index req_at, then pops the scoreboard and compares HI/LO.
  task automatic waitDone(input string tag, input int req_at, input int already);
    int   n;
    exp_t e;
    n = already;
    while (busy && n < 64) begin
      req = (n == req_at);
      n++;
      @(negedge clk);
    end
    req = 1'b0;
    if (sb_q.size() == 0) begin
      checkOutput({tag, "_sb_underflow"}, 64'd0, 64'd1);
    end else begin
      e = sb_q.pop_front();
      checkOutput({tag, "_busy_cycles"}, 64'(n), 64'(e.lat));
      checkOutput({tag, "_hi"}, {32'd0, hi}, {32'd0, e.hi});
      checkOutput({tag, "_lo"}, {32'd0, lo}, {32'd0, e.lo});
      model_hi = e.hi;
      model_lo = e.lo;
    end
  endtask

  task automatic runOp(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    applyStimulus(op, a, b, 1'b0);
    waitDone(tag, -1, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    int          illegal_before;

    reset    = 1'b1;
    req      = 1'b0;
    start    = 1'b0;
    hilo_op  = HILO_NONE;
    rs_val   = 32'd0;
    rt_val   = 32'd0;
    model_hi = 32'd0;
    model_lo = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    checkOutput("rst_busy", {63'd0, busy}, 64'd0);
    checkOutput("rst_hi", {32'd0, hi}, 64'd0);
    checkOutput("rst_lo", {32'd0, lo}, 64'd0);
    checkOutput("rst_hilo_out", {32'd0, hilo_out}, 64'd0);

    runOp("mult", HILO_MULT, 32'hFFFF_FFFF, 32'd2);
    checkOutput("mult_hi_const", {32'd0, hi}, {32'd0, 32'hFFFF_FFFF});
    checkOutput("mult_lo_const", {32'd0, lo}, {32'd0, 32'hFFFF_FFFE});
    runOp("multu", HILO_MULTU, 32'hFFFF_FFFF, 32'd2);
    checkOutput("multu_hi_const", {32'd0, hi}, 64'd1);
    runOp("div_neg", HILO_DIV, 32'hFFFF_FFF9, 32'd2);
    checkOutput("div_lo_const", {32'd0, lo}, {32'd0, 32'hFFFF_FFFD});
    runOp("div_ovf", HILO_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    runOp("divu", HILO_DIVU, 32'd100, 32'd7);
    runOp("divu_zero", HILO_DIVU, 32'd7, 32'd0);
    checkOutput("divu_zero_lo_kept", {32'd0, lo}, 64'd14);

    // req in the launch cycle: nothing starts, nothing is written.
    applyStimulus(HILO_MULT, 32'd3, 32'd4, 1'b1);
    checkOutput("req_start_busy", {63'd0, busy}, 64'd0);
    repeat (6) @(negedge clk);
    checkOutput("req_start_hi", {32'd0, hi}, {32'd0, model_hi});
    checkOutput("req_start_lo", {32'd0, lo}, {32'd0, model_lo});

    // req during RUN does not abort a committed operation.
    applyStimulus(HILO_MULT, 32'h0001_0000, 32'h0003_0000, 1'b0);
    waitDone("mult_req_run", 2, 0);

    applyStimulus(HILO_MTHI, 32'h1234_5678, 32'd0, 1'b0);
    checkOutput("mthi_hi", {32'd0, hi}, {32'd0, model_hi});
    hilo_op = HILO_MFHI;
    #1;
    checkOutput("mfhi_out", {32'd0, hilo_out}, {32'd0, 32'h1234_5678});
    @(negedge clk);
    applyStimulus(HILO_MTLO, 32'hCAFE_F00D, 32'd0, 1'b0);
    hilo_op = HILO_MFLO;
    #1;
    checkOutput("mflo_out", {32'd0, hilo_out}, {32'd0, 32'hCAFE_F00D});
    hilo_op = 4'd9;
    #1;
    checkOutput("unused_op_out", {32'd0, hilo_out}, 64'd0);
    hilo_op = HILO_NONE;
    @(negedge clk);
    applyStimulus(HILO_MTHI, 32'hDEAD_BEEF, 32'd0, 1'b1);
    checkOutput("mthi_req_hi", {32'd0, hi}, {32'd0, model_hi});

    // MTLO during RUN must be dropped; the monitor must see it.
    illegal_before = illegal_cnt;
    applyStimulus(HILO_MULT, 32'd7, 32'd6, 1'b0);
    hilo_op = HILO_MTLO;
    rs_val  = 32'h5555_5555;
    @(negedge clk);
    hilo_op = HILO_NONE;
    waitDone("mult_mt_busy", -1, 1);
    checkOutput("mt_busy_seen", 64'(illegal_cnt - illegal_before), 64'd1);

    // Back-to-back: the next launch goes out in the first idle cycle.
    runOp("b2b_multu", HILO_MULTU, 32'h8000_0001, 32'hFFFF_FFFF);
    runOp("b2b_div", HILO_DIV, 32'd17, 32'hFFFF_FFFB);

    // Reset in cycle 3 of a DIV aborts it and clears HI/LO.
    applyStimulus(HILO_DIV, 32'd1000, 32'd3, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb_q.delete();
    model_hi = 32'd0;
    model_lo = 32'd0;
    checkOutput("rst_run_busy", {63'd0, busy}, 64'd0);
    checkOutput("rst_run_hi", {32'd0, hi}, 64'd0);
    checkOutput("rst_run_lo", {32'd0, lo}, 64'd0);
    repeat (10) @(negedge clk);
    checkOutput("rst_run_lo_later", {32'd0, lo}, 64'd0);
    runOp("mult_after_rst", HILO_MULT, 32'hFFFF_0000, 32'h0001_2345);

    for (int i = 0; i < 8; i++) begin
      rop = 4'($urandom_range(1, 4));
      ra  = $urandom;
      rb  = $urandom;
      if (i == 3) rb = 32'd0;
      else if (i % 2 == 1) rb = $urandom_range(1, 20);
      runOp($sformatf("rand%0d", i), rop, ra, rb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
